// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU; resolves one quotient bit per cycle.
// Result is {remainder, quotient}, registered and held until the next completion.
module seq_divider #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_start,
   input  logic               i_signed_op,
   input  logic [WIDTH-1:0]   i_dividend,
   input  logic [WIDTH-1:0]   i_divisor,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_div_by_zero,
   output logic [2*WIDTH-1:0] o_div_ans
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

   state_e             r_state;
   state_e             w_state_nxt;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH-1:0]   r_dvsr;
   logic [CntW-1:0]    r_cnt;
   logic               r_neg_quo;
   logic               r_neg_rem;
   logic               r_div_by_zero;
   logic [2*WIDTH-1:0] r_ans;

   logic               w_accept;
   logic               w_dvsr_zero;
   logic [WIDTH-1:0]   w_dividend_mag;
   logic [WIDTH-1:0]   w_divisor_mag;
   logic [WIDTH:0]     w_rem_sh;
   logic [WIDTH:0]     w_trial;
   logic               w_last_step;
   logic [WIDTH-1:0]   w_quo_fix;
   logic [WIDTH-1:0]   w_rem_fix;

   assign w_accept       = (r_state == StIdle) && i_start;
   assign w_dvsr_zero    = (i_divisor == '0);
   assign w_dividend_mag = (i_signed_op && i_dividend[WIDTH-1]) ? -i_dividend : i_dividend;
   assign w_divisor_mag  = (i_signed_op && i_divisor[WIDTH-1])  ? -i_divisor  : i_divisor;

   // rem_sh < 2*divisor, so a WIDTH+1 bit trial cannot overflow; its MSB is the borrow
   assign w_rem_sh    = {r_rem, r_quo[WIDTH-1]};
   assign w_trial     = w_rem_sh - {1'b0, r_dvsr};
   assign w_last_step = (r_cnt == CntW'(WIDTH - 1));

   assign w_quo_fix = r_neg_quo ? -r_quo : r_quo;
   assign w_rem_fix = r_neg_rem ? -r_rem : r_rem;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      o_busy      = 1'b0;
      o_done      = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (i_start) begin
               w_state_nxt = w_dvsr_zero ? StDone : StRun;
            end
         end
         StRun: begin
            o_busy = 1'b1;
            if (w_last_step) begin
               w_state_nxt = StFix;
            end
         end
         StFix: begin
            o_busy      = 1'b1;
            w_state_nxt = StDone;
         end
         StDone: begin
            o_done      = 1'b1;
            w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rem         <= '0;
         r_quo         <= '0;
         r_dvsr        <= '0;
         r_cnt         <= '0;
         r_neg_quo     <= 1'b0;
         r_neg_rem     <= 1'b0;
         r_div_by_zero <= 1'b0;
         r_ans         <= '0;
      end else if (w_accept) begin
         r_rem         <= '0;
         r_quo         <= w_dividend_mag;
         r_dvsr        <= w_divisor_mag;
         r_cnt         <= '0;
         r_neg_quo     <= i_signed_op && (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
         r_neg_rem     <= i_signed_op && i_dividend[WIDTH-1];
         r_div_by_zero <= w_dvsr_zero;
         if (w_dvsr_zero) begin
            r_ans <= {i_dividend, {WIDTH{1'b1}}};
         end
      end else if (r_state == StRun) begin
         r_cnt <= r_cnt + 1'b1;
         if (!w_trial[WIDTH]) begin
            r_rem <= w_trial[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
         end else begin
            r_rem <= w_rem_sh[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
         end
      end else if (r_state == StFix) begin
         r_ans <= {w_rem_fix, w_quo_fix};
      end
   end

   assign o_div_by_zero = r_div_by_zero;
   assign o_div_ans     = r_ans;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: latency, sign rules, divide-by-zero, handshake and reset abort.
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        signed_op;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [63:0] div_ans;

   int errors = 0;
   int checks = 0;

   seq_divider #(.WIDTH(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_start      (start),
      .i_signed_op  (signed_op),
      .i_dividend   (dividend),
      .i_divisor    (divisor),
      .o_busy       (busy),
      .o_done       (done),
      .o_div_by_zero(div_by_zero),
      .o_div_ans    (div_ans)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Launch one operation from IDLE and check latency, busy span, result and done width.
   task automatic run_op(input string tag, input logic sop, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_ans, input logic exp_dz,
                         input int exp_lat, input logic disturb);
      int          lat_seen;
      int          busy_cnt;
      logic [63:0] ans_at_done;
      logic        dz_at_done;
      lat_seen    = -1;
      busy_cnt    = 0;
      ans_at_done = 'x;
      dz_at_done  = 1'bx;
      signed_op   = sop;
      dividend    = a;
      divisor     = b;
      start       = 1'b1;
      @(posedge clk);
      #1;
      start     = 1'b0;
      signed_op = ~sop;
      dividend  = $urandom;
      divisor   = $urandom;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (disturb && c == 5) begin
            start     = 1'b1;
            signed_op = 1'b1;
            dividend  = 32'h8000_0000;
            divisor   = 32'd3;
         end
         if (disturb && c == 6) begin
            start    = 1'b0;
            dividend = 32'h1234_5678;
            divisor  = 32'd0;
         end
         if (busy) busy_cnt++;
         if (done && lat_seen < 0) begin
            lat_seen    = c;
            ans_at_done = div_ans;
            dz_at_done  = div_by_zero;
         end
         if (lat_seen > 0 && c == lat_seen + 1) begin
            chk({tag, " done_width"}, {63'd0, done}, 64'd0);
            chk({tag, " idle_after"}, {63'd0, busy}, 64'd0);
            break;
         end
      end
      chk({tag, " latency"}, 64'(lat_seen), 64'(exp_lat));
      chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
      chk({tag, " div_ans"}, ans_at_done, exp_ans);
      chk({tag, " div_by_zero"}, {63'd0, dz_at_done}, {63'd0, exp_dz});
   endtask

   initial begin
      int done_cnt;
      int first_done;
      int second_done;
      logic [63:0] second_ans;

      reset     = 1'b1;
      start     = 1'b0;
      signed_op = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("reset busy", {63'd0, busy}, 64'd0);
      chk("reset done", {63'd0, done}, 64'd0);
      chk("reset dz", {63'd0, div_by_zero}, 64'd0);
      chk("reset ans", div_ans, 64'd0);

      // Unsigned 100/7 with a second start and operand churn during RUN
      run_op("u100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 34, 1'b1);
      run_op("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, 34, 1'b0);
      @(negedge clk);
      chk("ans held", div_ans, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      run_op("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 1'b0, 34, 1'b0);
      run_op("uFF_10", 1'b0, 32'hFFFF_FFFF, 32'h10, {32'h0000_000F, 32'h0FFF_FFFF}, 1'b0, 34,
             1'b0);
      run_op("s-100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1'b0, 34,
             1'b0);
      run_op("dz_u", 1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1'b1, 1, 1'b0);
      run_op("u9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0, 34, 1'b0);
      run_op("dz_s", 1'b1, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1'b1, 1, 1'b0);
      run_op("s9_3", 1'b1, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0, 34, 1'b0);
      run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0, 34, 1'b0);
      run_op("u_8000_FFFF", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, 1'b0, 34,
             1'b0);

      // start held high: second accept lands in the cycle after done
      first_done  = -1;
      second_done = -1;
      second_ans  = '0;
      signed_op   = 1'b0;
      dividend    = 32'd1000;
      divisor     = 32'd10;
      start       = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 80; c++) begin
         @(negedge clk);
         if (done && first_done < 0) begin
            first_done = c;
            chk("hold first ans", div_ans, {32'd0, 32'd100});
         end else if (done && second_done < 0) begin
            second_done = c;
            second_ans  = div_ans;
         end
         if (c == 35) begin
            chk("hold idle gap busy", {63'd0, busy}, 64'd0);
            dividend = 32'd1000;
            divisor  = 32'd3;
         end
         if (c == 36) begin
            chk("hold reaccept busy", {63'd0, busy}, 64'd1);
            start = 1'b0;
         end
         if (second_done > 0) break;
      end
      start = 1'b0;
      chk("hold first lat", 64'(first_done), 64'd34);
      chk("hold second lat", 64'(second_done), 64'd69);
      chk("hold second ans", second_ans, {32'd1, 32'd333});
      repeat (2) @(negedge clk);

      // Reset during RUN aborts with no done pulse
      signed_op = 1'b0;
      dividend  = 32'd100;
      divisor   = 32'd7;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int c = 1; c <= 10; c++) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("abort busy", {63'd0, busy}, 64'd0);
      chk("abort done", {63'd0, done}, 64'd0);
      chk("abort ans", div_ans, 64'd0);
      chk("abort dz", {63'd0, div_by_zero}, 64'd0);
      done_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      chk("abort no done", 64'(done_cnt), 64'd0);
      run_op("after_abort", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 34, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
